imem_stream_loader: RTL and testbench
=====================================

// Module: imem_stream_loader
// PURPOSE
//  Boot-time instruction loader directly upstream of the AES SIMD pipeline top.
//  Accepts a byte stream (valid/ready) from the host link, packs bytes into 21-bit instructions,
//  writes them sequentially into instruction memory starting at address 0, and holds the core in reset until the image is loaded.
//  Releases the core by deasserting core_rst. A reload pulse re-arms the loader for a new image.
// PARAMETERS
//  INSTR_W   21    instruction width; INSTR_BYTES = ceil(INSTR_W/8) = 3 (localparam)
//  ADDR_W    12    instruction memory address width (matches PC width)
//  DEPTH     4096  instruction memory words; header count > DEPTH is an error
// PORTS
//  clk         in   1        system clock
//  rst         in   1        asynchronous, active-high reset
//  rx_data     in   8        stream byte
//  rx_valid    in   1        rx_data valid
//  rx_ready    out  1        loader can accept a byte; a byte transfers when rx_valid && rx_ready
//  reload      in   1        single-cycle pulse; honoured only in RUN or ERROR
//  imem_we     out  1        instruction memory write strobe (one cycle per instruction)
//  imem_addr   out  ADDR_W   write address
//  imem_wdata  out  INSTR_W  write data
//  core_rst    out  1        active-high reset to pipeline top; 1 in every state except RUN
//  load_done   out  1        1 while in RUN
//  err         out  1        1 while in ERROR
// BEHAVIOUR
//  Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, load_done=0, err=0, state=LEN_LO,
//   byte index=0, instr count=0. rx_ready is decoded from state: 1 in LEN_LO/LEN_HI/DATA(/CHK), 0 in RUN/ERROR.
//  Frame: len[7:0], len[15:8] (little-endian count N), then N x 3 bytes little-endian per instruction.
//   Byte 2 of each instruction keeps bits [4:0] only (word = {b2[4:0],b1,b0}); bits [7:5] are discarded.
//  FSM: LEN_LO -byte-> LEN_HI; LEN_HI -byte-> N==0: RUN (or CHK); N>DEPTH: ERROR; else DATA.
//   DATA: byte index counts 0..2; on index-2 handshake (cycle T) imem_we=1, imem_wdata=packed word at T+1;
//   imem_addr holds the address of that write and increments after it. After N-th word: RUN (or CHK) at T+1.
//   RUN: core_rst=0 and load_done=1 from the cycle after state entry (registered), so the final write lands first.
//   reload in RUN or ERROR: next state LEN_LO, address/counters cleared, core_rst=1 next cycle. Ignored elsewhere.
//  Backpressure: gaps in rx_valid stall the FSM without side effects; no byte is ever dropped while rx_ready=1.
//  rst mid-load: everything returns to reset values immediately; partial image is abandoned, core stays in reset.
//  Address never wraps: N<=DEPTH guarantees last write address = N-1.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: extra state CHK after last data byte (or after LEN_HI when N==0); one trailing
//   byte must equal XOR of all preceding frame bytes (len bytes included). Match -> RUN; mismatch -> ERROR.
//   Writes already issued are not retracted; core stays in reset on mismatch.
//  Not defined: no CHK state, no trailing byte; frame ends after last data byte.
// STRUCTURE
//  Package aes_loader_pkg: state enum (LEN_LO, LEN_HI, DATA, CHK, RUN, ERROR), INSTR_BYTES, default INSTR_W/ADDR_W/DEPTH.
//  One sub-module: rx_byte_packer (byte index counter + 3-byte shift register -> INSTR_W word with word_valid pulse).
//  FSM, address counter, instruction counter, checksum accumulator and output registers live in the top of this block.
// TESTING
//  1. Stream 02 00 | 11 22 33 | AA BB 1F -> writes addr0=0x132211, addr1=0x1FBBAA; core_rst=0 two cycles after last accept.
//  2. Stream 00 00 -> no imem_we, RUN entered, load_done=1, rx_ready=0.
//  3. Stream 01 10 (N=4097) -> ERROR, err=1, core_rst=1, no writes; then reload -> LEN_LO, rx_ready=1, err=0.
//  4. Random rx_valid gaps during test 1 stream -> identical writes/addresses; assert rst after 4 bytes -> all outputs
//     at reset values, re-send full frame -> correct image.
//  5. CHECKSUM_EN: 01 00 01 02 03 01 -> write addr0=0x030201, RUN; same with trailing 00 -> ERROR, core_rst stays 1.
//  6. reload pulse coincident with rx_valid in RUN -> byte not accepted, LEN_LO next cycle, subsequent frame loads at addr0.

Source files
------------

// File: rtl/aes_loader_pkg.sv
// Shared types and defaults for the boot-time instruction image loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t      loader FSM states (CHK is reachable only in checksum builds)
//   INSTR_W_DEF  default instruction width
//   ADDR_W_DEF   default instruction memory address width (same as PC width)
//   DEPTH_DEF    default instruction memory depth in words
//   INSTR_BYTES  stream bytes per instruction, ceil(INSTR_W_DEF/8)
package aes_loader_pkg;

  localparam int INSTR_W_DEF = 21;
  localparam int ADDR_W_DEF  = 12;
  localparam int DEPTH_DEF   = 4096;
  localparam int INSTR_BYTES = (INSTR_W_DEF + 7) / 8;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    RUN,
    ERROR
  } state_t;

endpackage

// File: rtl/rx_byte_packer.sv
// Packs little-endian stream bytes into one instruction word.
// Latency: word_vld/word_dat are combinational on the handshake of the last byte of a word.
// Backpressure: none of its own; it advances only on byte_vld, so caller stalls hold its state.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        synchronous restart of the byte index (caller asserts outside the data phase)
//   byte_vld   one accepted stream byte this cycle
//   byte_dat   the accepted byte
//   word_vld   pulse: byte_dat completes a word this cycle
//   word_dat   {last byte (truncated), ..., first byte}
// Assumes INSTR_W > 16 (three or more bytes per word), which the loader always uses.
module rx_byte_packer
  import aes_loader_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               byte_vld,
  input  logic [7:0]         byte_dat,
  output logic               word_vld,
  output logic [INSTR_W-1:0] word_dat
);

  localparam int NB = (INSTR_W + 7) / 8;
  localparam int PW = (NB - 1) * 8;
  localparam int IW = $clog2(NB);

  logic [IW-1:0]   idx_q;
  logic [PW-1:0]   prev_q;
  logic [NB*8-1:0] full;
  logic            last_byte;
  logic            unused_pad;

  assign last_byte = (idx_q == IW'(NB - 1));
  // Earlier bytes sit in the low bits, so the word is the current byte on top of them.
  assign full      = {byte_dat, prev_q};
  assign word_vld  = byte_vld && last_byte;
  assign word_dat  = full[INSTR_W-1:0];
  // High bits of the top byte carry no instruction content and are dropped.
  assign unused_pad = ^full[NB*8-1:INSTR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      prev_q <= '0;
    end else if (clr) begin
      idx_q  <= '0;
    end else if (byte_vld) begin
      // Shift right so the first byte of a word ends up in the lowest lane.
      prev_q <= {byte_dat, prev_q[PW-1:8]};
      idx_q  <= last_byte ? '0 : idx_q + IW'(1);
    end
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes instructions from address 0, then releases the core.
// Latency: a write strobe follows the word's last byte by one cycle; core_rst falls two cycles after the frame's last byte.
// Backpressure: rx_ready is high throughout LEN_LO/LEN_HI/DATA/CHK; gaps in rx_valid just stall; low in RUN/ERROR.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rx_data      stream byte; rx_valid/rx_ready handshake
//   reload       one-cycle pulse, re-arms the loader from RUN or ERROR, ignored otherwise
//   imem_we      one-cycle write strobe per instruction
//   imem_addr    write address (0..N-1)
//   imem_wdata   packed instruction {b2[4:0], b1, b0}
//   core_rst     reset to the pipeline, low only once settled in RUN
//   load_done    high once settled in RUN
//   err          high while in ERROR (bad length or checksum mismatch)
module imem_stream_loader
  import aes_loader_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_rst,
  output logic               load_done,
  output logic               err
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
`else
  localparam state_t END_ST = RUN;
`endif

  state_t             state_q;
  state_t             state_d;
  logic [7:0]         len_lo_q;
  logic [15:0]        len_q;
  logic [15:0]        cnt_q;
  logic [15:0]        len_now;
  logic               acc;
  logic               in_data;
  logic               word_vld;
  logic [INSTR_W-1:0] word_dat;
  logic               last_word;
  logic               do_reload;

  assign acc       = rx_valid && rx_ready;
  assign in_data   = (state_q == DATA);
  assign len_now   = {rx_data, len_lo_q};
  assign last_word = word_vld && ((cnt_q + 16'd1) == len_q);
  assign do_reload = reload && ((state_q == RUN) || (state_q == ERROR));

  rx_byte_packer #(
    .INSTR_W (INSTR_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (!in_data),
    .byte_vld (acc && in_data),
    .byte_dat (rx_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every frame byte before the checksum; restarts on the first length byte.
  logic [7:0] chk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= '0;
    end else if (acc) begin
      chk_q <= (state_q == LEN_LO) ? rx_data : (chk_q ^ rx_data);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    err      = 1'b0;
    case (state_q)
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (len_now == 16'd0)             state_d = END_ST;
          else if ({1'b0, len_now} > DEPTH_L) state_d = ERROR;
          else                              state_d = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (last_word) state_d = END_ST;
      end
      CHK: begin
        rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (rx_valid) state_d = (rx_data == chk_q) ? RUN : ERROR;
`endif
      end
      RUN: begin
        if (reload) state_d = LEN_LO;
      end
      ERROR: begin
        err = 1'b1;
        if (reload) state_d = LEN_LO;
      end
      default: state_d = LEN_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LEN_LO;
      len_lo_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      imem_we <= word_vld;
      if (word_vld) begin
        imem_wdata <= word_dat;
        cnt_q      <= cnt_q + 16'd1;
      end
      if ((state_q == LEN_LO) && acc) len_lo_q <= rx_data;
      if ((state_q == LEN_HI) && acc) len_q    <= len_now;
      // imem_addr names the word being written this cycle and advances afterwards.
      if (imem_we) imem_addr <= imem_addr + ADDR_W'(1);
      if (do_reload) begin
        cnt_q     <= '0;
        imem_addr <= '0;
      end
      // Release only after a full cycle in RUN so the final write precedes it;
      // a reload re-asserts reset on the very next cycle.
      load_done <= (state_q == RUN) && (state_d == RUN);
      core_rst  <= !((state_q == RUN) && (state_d == RUN));
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
`timescale 1ns/1ps
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [20:0] imem_wdata;
  logic        core_rst;
  logic        load_done;
  logic        err;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  always #5 clk = ~clk;

  imem_stream_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .err        (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: frame-level view ----------------
  // phase 0 = collecting frame bytes, 1 = running, 2 = error
  int          m_phase = 0;
  logic [7:0]  m_fr[$];
  int          m_age   = 0;
  int          m_words = 0;
  bit          m_we    = 1'b0;
  logic [11:0] m_addr  = '0;
  logic [20:0] m_data  = '0;

  task automatic model_byte(input logic [7:0] b);
    int n;
    int nw;
    logic [7:0] x;
    logic [7:0] lo;
    logic [7:0] hi;
    m_fr.push_back(b);
    n = m_fr.size();
    if (n < 2) return;
    lo = m_fr[0];
    hi = m_fr[1];
    nw = int'({hi, lo});
    if (n == 2 && nw > 4096) begin
      m_phase = 2;
      return;
    end
    if (n > 2 && n <= 2 + 3 * nw && ((n - 2) % 3) == 0) begin
      m_we   = 1'b1;
      m_addr = 12'(m_words);
      m_data = {b[4:0], m_fr[n-2], m_fr[n-3]};
      m_words++;
    end
    if (n == 2 + 3 * nw + CHK_BYTES) begin
      x = 8'h00;
      for (int i = 0; i < n - CHK_BYTES; i++) x = x ^ m_fr[i];
      if (CHK_BYTES == 0 || x == b) begin
        m_phase = 1;
        m_age   = 0;
      end else begin
        m_phase = 2;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_fr.delete();
      m_age   = 0;
      m_words = 0;
      m_we    = 1'b0;
    end else begin
      m_we = 1'b0;
      case (m_phase)
        0: if (rx_valid) model_byte(rx_data);
        1: begin
          if (reload) begin
            m_phase = 0;
            m_fr.delete();
            m_words = 0;
          end else begin
            m_age++;
          end
        end
        default: begin
          if (reload) begin
            m_phase = 0;
            m_fr.delete();
            m_words = 0;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare + image capture ----------------
  logic [20:0] img [16];
  int          wcount = 0;
  logic        exp_ld;

  always @(negedge clk) begin
    exp_ld = (m_phase == 1) && (m_age >= 1);
    check("rx_ready", rx_ready, (m_phase == 0));
    check("err", err, (m_phase == 2));
    check("load_done", load_done, exp_ld);
    check("core_rst", core_rst, !exp_ld);
    check("imem_we", imem_we, m_we);
    if (imem_we && m_we) begin
      check("imem_addr", imem_addr, m_addr);
      check("imem_wdata", imem_wdata, m_data);
    end
    if (imem_we) begin
      if (imem_addr < 12'd16) img[imem_addr[3:0]] = imem_wdata;
      wcount++;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] fq[$];

  task automatic frame_start(input int n);
    fq.delete();
    fq.push_back(n[7:0]);
    fq.push_back(n[15:8]);
  endtask

  task automatic frame_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    fq.push_back(b0);
    fq.push_back(b1);
    fq.push_back(b2);
  endtask

  task automatic frame_end();
    logic [7:0] x;
    x = 8'h00;
    if (CHK_BYTES != 0) begin
      foreach (fq[i]) x = x ^ fq[i];
      fq.push_back(x);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send_byte(input logic [7:0] b, input int gaps);
    int t;
    for (int i = 0; i < gaps; i++) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte 0x%0h not accepted within 50 cycles", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gmax);
    foreach (fq[i]) send_byte(fq[i], (gmax == 0) ? 0 : int'($urandom_range(0, gmax)));
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = '0;
    wcount = 0;
  endtask

  task automatic build_t1();
    frame_start(2);
    frame_word(8'h11, 8'h22, 8'h33);
    frame_word(8'hAA, 8'hBB, 8'h1F);
    frame_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    logic [7:0] r0, r1, r2;
    logic [20:0] w;
    clear_img();
    repeat (3) @(negedge clk);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_load_done", load_done, 0);
    check("rst_err", err, 0);
    check("rst_rx_ready", rx_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: two-word image, contiguous stream
    build_t1();
    send_frame(0);
    check("t1_core_rst_t1", core_rst, 1);
    @(negedge clk);
    check("t1_core_rst_t2", core_rst, 0);
    repeat (2) @(negedge clk);
    check("t1_img0", img[0], 21'h132211);
    check("t1_img1", img[1], 21'h1FBBAA);
    check("t1_wcount", wcount, 2);
    check("t1_load_done", load_done, 1);
    check("t1_rx_ready", rx_ready, 0);

    // Test 2: empty image
    pulse_reload();
    check("t2_core_rst_reload", core_rst, 1);
    clear_img();
    frame_start(0);
    frame_end();
    send_frame(0);
    repeat (3) @(negedge clk);
    check("t2_wcount", wcount, 0);
    check("t2_load_done", load_done, 1);
    check("t2_rx_ready", rx_ready, 0);

    // Test 3: oversize length
    pulse_reload();
    clear_img();
    frame_start(4097);
    send_frame(0);
    repeat (2) @(negedge clk);
    check("t3_err", err, 1);
    check("t3_core_rst", core_rst, 1);
    check("t3_rx_ready", rx_ready, 0);
    check("t3_wcount", wcount, 0);
    pulse_reload();
    check("t3_reload_rx_ready", rx_ready, 1);
    check("t3_reload_err", err, 0);

    // Test 4: gapped stream, then reset mid-frame and reload from scratch
    clear_img();
    build_t1();
    send_frame(3);
    repeat (3) @(negedge clk);
    check("t4_gap_img0", img[0], 21'h132211);
    check("t4_gap_img1", img[1], 21'h1FBBAA);
    check("t4_gap_wcount", wcount, 2);
    pulse_reload();
    for (int i = 0; i < 4; i++) send_byte(fq[i], int'($urandom_range(0, 2)));
    #2 rst = 1'b1;
    #1;
    check("t4_rst_imem_we", imem_we, 0);
    check("t4_rst_imem_addr", imem_addr, 0);
    check("t4_rst_core_rst", core_rst, 1);
    check("t4_rst_load_done", load_done, 0);
    check("t4_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_img();
    @(negedge clk);
    send_frame(2);
    repeat (3) @(negedge clk);
    check("t4_re_img0", img[0], 21'h132211);
    check("t4_re_img1", img[1], 21'h1FBBAA);
    check("t4_re_wcount", wcount, 2);

    // Test 6: reload coincident with a valid byte in RUN
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk);
    reload   = 1'b0;
    rx_valid = 1'b0;
    check("t6_len_lo_ready", rx_ready, 1);
    clear_img();
    frame_start(1);
    frame_word(8'h44, 8'h55, 8'h66);
    frame_end();
    send_frame(0);
    repeat (3) @(negedge clk);
    check("t6_img0", img[0], 21'h065544);
    check("t6_wcount", wcount, 1);

    // Random frames with random gaps
    for (int r = 0; r < 10; r++) begin
      pulse_reload();
      clear_img();
      n = int'($urandom_range(1, 6));
      frame_start(n);
      for (int k = 0; k < n; k++) begin
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        frame_word(r0, r1, r2);
      end
      frame_end();
      send_frame(r % 3);
      repeat (3) @(negedge clk);
      check("rnd_wcount", wcount, n);
      check("rnd_load_done", load_done, 1);
      for (int k = 0; k < n; k++) begin
        r0 = fq[2 + 3 * k];
        r1 = fq[3 + 3 * k];
        r2 = fq[4 + 3 * k];
        w  = {r2[4:0], r1, r0};
        check("rnd_img", img[k], w);
      end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Test 5: checksum match and mismatch
    pulse_reload();
    clear_img();
    fq.delete();
    fq.push_back(8'h01); fq.push_back(8'h00);
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    fq.push_back(8'h01);
    send_frame(0);
    repeat (3) @(negedge clk);
    check("t5_img0", img[0], 21'h030201);
    check("t5_load_done", load_done, 1);
    pulse_reload();
    clear_img();
    fq[5] = 8'h00;
    send_frame(0);
    repeat (3) @(negedge clk);
    check("t5_bad_err", err, 1);
    check("t5_bad_core_rst", core_rst, 1);
    check("t5_bad_wcount", wcount, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
